core_cmd_driver: RTL

- Host-side master that drives the compute core's external port: BRAM word writes, BRAM word reads, and instruction issue.
- Accepts one request at a time from a valid/ready host channel and sequences the core's command/data pins.
- For instructions: writes the command, waits for done, clears the command to NOP, then returns a response.
- Sits between the host/UART bridge and the compute core; it is the initiator for the core's command interface.

---
 rtl/core_cmd_driver.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/core_cmd_driver.sv
// Host-side command master for the compute core: sequences BRAM word writes/reads,
// command-register loads and full instruction runs (issue, wait for done, NOP, drain).
module core_cmd_driver #(
  parameter int            READ_LAT = 2,
  parameter int            TW       = 20,
  parameter logic [TW-1:0] TIMEOUT  = 20'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [9:0]  req_addr,
  input  logic [63:0] req_data,
  input  logic [34:0] req_cmd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic [9:0]  address_ext,
  output logic [63:0] dina_ext,
  output logic        wea_ext,
  output logic [34:0] command_in,
  output logic        command_we0,
  output logic        command_we1,
  input  logic [63:0] doutb_ext,
  input  logic        done_ins_computation,
  input  logic        error_trng
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_RD, S_LD1, S_EX_ISSUE, S_EX_WAIT, S_EX_CLEAR, S_EX_DRAIN, S_RSP
  } state_t;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_EXEC    = 2'd2;
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_TRNG    = 2'd2;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          trng_q, trng_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [63:0]   rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic [9:0]    addr_q, addr_d;
  logic [63:0]   dina_q, dina_d;
  logic          wea_q, wea_d;
  logic [34:0]   cmd_q, cmd_d;
  logic          we0_q, we0_d;
  logic          we1_q, we1_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    trng_d       = trng_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    addr_d       = addr_q;
    dina_d       = dina_q;
    cmd_d        = cmd_q;
    // Strobes default low so every core write is a single-cycle pulse.
    wea_d        = 1'b0;
    we0_d        = 1'b0;
    we1_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d  = 1'b0;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
          case (req_op)
            OP_WRITE: begin
              state_d = S_WR;
              addr_d  = req_addr;
              dina_d  = req_data;
              wea_d   = 1'b1;
            end
            OP_READ: begin
              state_d = S_RD;
              addr_d  = req_addr;
              cnt_d   = '0;
            end
            OP_EXEC: begin
              state_d = S_EX_ISSUE;
              cmd_d   = req_cmd;
              we0_d   = 1'b1;
            end
            default: begin
              state_d = S_LD1;
              cmd_d   = req_cmd;
              we1_d   = 1'b1;
            end
          endcase
        end
      end
      S_WR, S_LD1: begin
        state_d     = S_RSP;
        rsp_valid_d = 1'b1;
      end
      S_RD: begin
        if (cnt_q == TW'(READ_LAT)) begin
          rsp_data_d  = doutb_ext;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EX_ISSUE: begin
        cnt_d   = '0;
        trng_d  = 1'b0;
        state_d = S_EX_WAIT;
      end
      S_EX_WAIT: begin
        trng_d = trng_q | error_trng;
        // done is tested first so it wins over a simultaneous timeout.
        if (done_ins_computation) begin
          rsp_status_d = trng_d ? ST_TRNG : ST_OK;
          cmd_d        = '0;
          we0_d        = 1'b1;
          state_d      = S_EX_CLEAR;
        end else if (cnt_q == TIMEOUT - 1'b1) begin
          rsp_status_d = ST_TIMEOUT;
          cmd_d        = '0;
          we0_d        = 1'b1;
          state_d      = S_EX_CLEAR;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EX_CLEAR: state_d = S_EX_DRAIN;
      S_EX_DRAIN: begin
        if (!done_ins_computation) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      trng_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
      addr_q       <= '0;
      dina_q       <= '0;
      wea_q        <= 1'b0;
      cmd_q        <= '0;
      we0_q        <= 1'b0;
      we1_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trng_q       <= trng_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      addr_q       <= addr_d;
      dina_q       <= dina_d;
      wea_q        <= wea_d;
      cmd_q        <= cmd_d;
      we0_q        <= we0_d;
      we1_q        <= we1_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign address_ext = addr_q;
  assign dina_ext    = dina_q;
  assign wea_ext     = wea_q;
  assign command_in  = cmd_q;
  assign command_we0 = we0_q;
  assign command_we1 = we1_q;

endmodule
